produto_bcd: RTL

Sequential binary-to-BCD converter that sits directly downstream of the shift-add multiplier. It captures the 8-bit Produto when the multiplier pulses Done. It converts the value with the shift-add-3 (double-dabble) algorithm, one iteration per clock. It presents the result as packed BCD digits for the display stage. It uses the same St/Idle/Done handshake style as the multiplier.

---
 rtl/produto_bcd.sv | 108 ++++++++++
 1 files changed

// File: rtl/produto_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock).
// Optional 7-segment output when SEG7_ENCODER_EN is defined.
module produto_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  St,
  input  logic [WIDTH-1:0]      Binario,
  output logic                  Idle,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd
`ifdef SEG7_ENCODER_EN
  ,
  output logic [7*DIGITS-1:0]   Seg
`endif
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, FIM} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sr, sr_adj, sr_shl;
  logic [CW-1:0]   cnt;
  logic            last;

  // Add-3 correction on every BCD nibble, all in parallel, before the shift.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  assign sr_shl = {sr_adj[SW-2:0], 1'b0};
  assign last   = (cnt == CW'(WIDTH-1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (St) state_nxt = CONV;
      CONV:    if (last) state_nxt = FIM;
      FIM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Idle = (state == IDLE);
  assign Done = (state == FIM);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sr  <= '0;
      cnt <= '0;
      Bcd <= '0;
    end else begin
      case (state)
        IDLE: if (St) begin
          sr  <= {{(4*DIGITS){1'b0}}, Binario};
          cnt <= '0;
        end
        CONV: begin
          sr  <= sr_shl;
          cnt <= cnt + CW'(1);
          if (last) Bcd <= sr_shl[SW-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

`ifdef SEG7_ENCODER_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Decoded from the same post-shift value that loads Bcd, so both update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DIGITS; i++) Seg[7*i +: 7] <= 7'b0111111;
    end else if (state == CONV && last) begin
      for (int i = 0; i < DIGITS; i++) Seg[7*i +: 7] <= seg7(sr_shl[WIDTH+4*i +: 4]);
    end
  end
`endif

endmodule
